// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_ZERO = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_funct_dec.sv
// rtl/mips_funct_dec.sv - R-type funct field to ALU function code
module mips_funct_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_f,
  output logic       o_illegal
);

  always_comb begin
    o_alu_f   = ALU_ZERO;
    o_illegal = 1'b0;
    case (i_funct)
      FN_ADD:  o_alu_f = ALU_ADD;
      FN_SUB:  o_alu_f = ALU_SUB;
      FN_AND:  o_alu_f = ALU_AND;
      FN_OR:   o_alu_f = ALU_OR;
      FN_SLT:  o_alu_f = ALU_SLT;
      FN_SRL:  o_alu_f = ALU_SRL;
      FN_SRA:  o_alu_f = ALU_SRA;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multi-cycle MIPS control FSM driving datapath selects and strobes
module mips_mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] alu_f,
  output logic       illegal_op
);

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic       w_cnt_done;
  logic       w_hold_state;
  logic [3:0] w_fn_alu_f;
  logic       w_fn_illegal;

  logic       w_pc_en, w_iord, w_mem_write, w_ir_write, w_reg_dst;
  logic       w_mem_to_reg, w_reg_write, w_alu_src_a, w_illegal;
  logic [1:0] w_alu_src_b, w_pc_src;
  logic [3:0] w_alu_f;

  mips_funct_dec u_funct_dec (
    .i_funct   (funct),
    .o_alu_f   (w_fn_alu_f),
    .o_illegal (w_fn_illegal)
  );

  assign w_cnt_done   = (r_cnt == LAT_LAST);
  assign w_hold_state = (r_state == FETCH) || (r_state == MEMRD);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= FETCH;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_hold_state && !w_cnt_done) r_cnt <= r_cnt + 4'd1;
      else                             r_cnt <= 4'd0;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_pc_en      = 1'b0;
    w_iord       = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_B;
    w_pc_src     = PCSRC_ALU;
    w_alu_f      = ALU_ADD;
    w_illegal    = 1'b0;
    case (r_state)
      FETCH: begin
        w_alu_src_b = SRCB_FOUR;
        w_ir_write  = w_cnt_done;
        w_pc_en     = w_cnt_done;
        if (w_cnt_done) w_next = DECODE;
      end
      DECODE: begin
        w_alu_src_b = SRCB_IMM_SH;
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = EXECUTE;
          OP_BEQ:       w_next = BRANCH;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JUMP;
          default: begin
            w_next    = FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_next      = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        w_iord = 1'b1;
        if (w_cnt_done) w_next = MEMWB;
      end
      MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_next       = FETCH;
      end
      MEMWR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        w_next      = FETCH;
      end
      EXECUTE: begin
        // An unknown funct aborts straight to FETCH so no register write happens.
        w_alu_src_a = 1'b1;
        w_alu_f     = w_fn_alu_f;
        w_illegal   = w_fn_illegal;
        w_next      = w_fn_illegal ? FETCH : ALUWB;
      end
      ALUWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        w_next      = FETCH;
      end
      BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_f     = ALU_SUB;
        w_pc_src    = PCSRC_ALUOUT;
        w_pc_en     = zero;
        w_next      = FETCH;
      end
      ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_next      = ADDIWB;
      end
      ADDIWB: begin
        w_reg_write = 1'b1;
        w_next      = FETCH;
      end
      JUMP: begin
        w_pc_src = PCSRC_JUMP;
        w_pc_en  = 1'b1;
        w_next   = FETCH;
      end
      default: w_next = FETCH;
    endcase
  end

  // While reset is low the state register may still hold an aborted instruction; mask it.
  always_comb begin
    pc_en      = reset_n & w_pc_en;
    iord       = reset_n & w_iord;
    mem_write  = reset_n & w_mem_write;
    ir_write   = reset_n & w_ir_write;
    reg_dst    = reset_n & w_reg_dst;
    mem_to_reg = reset_n & w_mem_to_reg;
    reg_write  = reset_n & w_reg_write;
    alu_src_a  = reset_n & w_alu_src_a;
    alu_src_b  = reset_n ? w_alu_src_b : SRCB_B;
    pc_src     = reset_n ? w_pc_src : PCSRC_ALU;
    alu_f      = reset_n ? w_alu_f : ALU_ADD;
    illegal_op = reset_n & w_illegal;
  end

endmodule
